running_min_drain: RTL and testbench



---
 rtl/running_min_drain.sv | 160 ++++++++++++++++
 tb/tb_running_min_drain.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/running_min_drain.sv
// Snapshots per-lane running minima into a 2-bank ping-pong buffer and drains one lane per beat.
// Optional threshold compare (thresh_in / out_match) is enabled by defining RUNMIN_DRAIN_THRESH_EN.
module running_min_drain_lane #(
  parameter int IDX_W  = 9,
  parameter int DIST_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              wsel_i,
  input  logic              rsel_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DIST_W-1:0] dist_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic [DIST_W-1:0] dist_o
);
  logic [1:0][IDX_W-1:0]  idx_q;
  logic [1:0][DIST_W-1:0] dist_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      idx_q[wsel_i]  <= idx_i;
      dist_q[wsel_i] <= dist_i;
    end
  end

  assign idx_o  = idx_q[rsel_i];
  assign dist_o = dist_q[rsel_i];
endmodule

module running_min_drain #(
  parameter int NUM_LANES = 8,
  parameter int IDX_W     = 9,
  parameter int DIST_W    = 11,
  parameter int QID_W     = 11,
  localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic                        query_last_in,
  input  logic [NUM_LANES*IDX_W-1:0]  lane_idx_in,
  input  logic [NUM_LANES*DIST_W-1:0] lane_dist_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            out_idx,
  output logic [DIST_W-1:0]           out_dist,
  output logic [LANE_W-1:0]           out_lane,
  output logic [QID_W-1:0]            out_qid,
  output logic                        out_last,
  output logic                        overflow,
`ifdef RUNMIN_DRAIN_THRESH_EN
  input  logic [DIST_W-1:0]           thresh_in,
  output logic                        out_match,
`endif
  output logic                        busy
);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                          state_q, state_d;
  logic [1:0]                      count_q, count_d;
  logic                            wr_ptr_q, rd_ptr_q, overflow_q;
  logic [LANE_W-1:0]               lane_cnt_q;
  logic [QID_W-1:0]                qid_cnt_q;
  logic [1:0][QID_W-1:0]           qid_bank_q;
  logic [NUM_LANES-1:0][IDX_W-1:0]  rd_idx;
  logic [NUM_LANES-1:0][DIST_W-1:0] rd_dist;
  logic cap, cap_accept, beat_acc, final_pop;

  assign cap        = valid_in & query_last_in;
  assign beat_acc   = (state_q == STREAM) & out_ready;
  assign final_pop  = beat_acc & (lane_cnt_q == LAST_LANE);
  // A full buffer can still take a capture when the bank under read is freed on this edge.
  assign cap_accept = cap & ((count_q != 2'd2) | final_pop);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    running_min_drain_lane #(.IDX_W(IDX_W), .DIST_W(DIST_W)) u_lane (
      .clk    (clk),
      .we_i   (cap_accept),
      .wsel_i (wr_ptr_q),
      .rsel_i (rd_ptr_q),
      .idx_i  (lane_idx_in[l*IDX_W +: IDX_W]),
      .dist_i (lane_dist_in[l*DIST_W +: DIST_W]),
      .idx_o  (rd_idx[l]),
      .dist_o (rd_dist[l])
    );
  end

  always_comb begin
    count_d = count_q;
    if (cap_accept && !final_pop)      count_d = count_q + 2'd1;
    else if (!cap_accept && final_pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != 2'd0) state_d = STREAM;
      STREAM:  if (final_pop && count_d == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_idx   = '0;
    out_dist  = '0;
    out_lane  = '0;
    out_qid   = '0;
    out_last  = 1'b0;
    if (state_q == STREAM) begin
      out_valid = 1'b1;
      out_idx   = rd_idx[lane_cnt_q];
      out_dist  = rd_dist[lane_cnt_q];
      out_lane  = lane_cnt_q;
      out_qid   = qid_bank_q[rd_ptr_q];
      out_last  = (lane_cnt_q == LAST_LANE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      lane_cnt_q <= '0;
      qid_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      // Dropped captures still consume an id so ids track queries.
      if (cap)               qid_cnt_q  <= qid_cnt_q + QID_W'(1);
      if (cap_accept)        wr_ptr_q   <= ~wr_ptr_q;
      if (cap && !cap_accept) overflow_q <= 1'b1;
      if (final_pop) begin
        lane_cnt_q <= '0;
        rd_ptr_q   <= ~rd_ptr_q;
      end else if (beat_acc) begin
        lane_cnt_q <= lane_cnt_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_accept) qid_bank_q[wr_ptr_q] <= qid_cnt_q;
  end

  assign overflow = overflow_q;
  assign busy     = (count_q != 2'd0);

`ifdef RUNMIN_DRAIN_THRESH_EN
  assign out_match = out_valid & (out_dist <= thresh_in);
`endif
endmodule

// File: tb/tb_running_min_drain.sv
// Directed bench for running_min_drain: latency, backpressure, ping-pong, overflow, capture-on-pop, reset.
module tb_running_min_drain;
  localparam int NL = 8, IW = 9, DW = 11, QW = 11, LW = 3;

  logic clk = 1'b0;
  logic rst, valid_in, query_last_in, out_ready;
  logic [NL*IW-1:0] lane_idx_in;
  logic [NL*DW-1:0] lane_dist_in;
  logic out_valid, out_last, overflow, busy;
  logic [IW-1:0] out_idx;
  logic [DW-1:0] out_dist;
  logic [LW-1:0] out_lane;
  logic [QW-1:0] out_qid;
`ifdef RUNMIN_DRAIN_THRESH_EN
  logic [DW-1:0] thresh_in;
  logic out_match;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  running_min_drain #(.NUM_LANES(NL), .IDX_W(IW), .DIST_W(DW), .QID_W(QW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .query_last_in(query_last_in),
    .lane_idx_in(lane_idx_in), .lane_dist_in(lane_dist_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_dist(out_dist),
    .out_lane(out_lane), .out_qid(out_qid), .out_last(out_last), .overflow(overflow),
`ifdef RUNMIN_DRAIN_THRESH_EN
    .thresh_in(thresh_in), .out_match(out_match),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ib, input int db);
    for (int l = 0; l < NL; l++) begin
      lane_idx_in[l*IW +: IW]  = IW'(ib + l);
      lane_dist_in[l*DW +: DW] = DW'(db + l);
    end
  endtask

  task automatic set_cap(input logic c);
    valid_in      = c;
    query_last_in = c;
  endtask

  task automatic chk_beat(input string tag, input int lane, input int qid, input int ib, input int db);
    chk({tag, "_v"},    out_valid, 1);
    chk({tag, "_lane"}, out_lane, lane);
    chk({tag, "_qid"},  out_qid, qid);
    chk({tag, "_idx"},  out_idx, ib + lane);
    chk({tag, "_dist"}, out_dist, db + lane);
    chk({tag, "_last"}, out_last, (lane == NL - 1) ? 1 : 0);
  endtask

  initial begin
    int e;
    int k;
    bit found;
    rst = 1'b1; set_cap(1'b0); out_ready = 1'b0;
    lane_idx_in = '0; lane_dist_in = '0;
`ifdef RUNMIN_DRAIN_THRESH_EN
    thresh_in = DW'(104);
`endif
    tick; tick;
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_qid", out_qid, 0);
    chk("rst_last", out_last, 0);

    // valid_in alone must not capture
    load(5, 50); valid_in = 1'b1; tick; valid_in = 1'b0;
    chk("noncap_busy", busy, 0);
    tick;
    chk("noncap_valid", out_valid, 0);

    // single query; input data changes after capture must not leak in
    load(10, 100); set_cap(1'b1); tick; set_cap(1'b0); load(50, 500);
    chk("t1_lat_valid", out_valid, 0);
    chk("t1_busy", busy, 1);
    out_ready = 1'b1;
    tick;
    for (int i = 0; i < NL; i++) begin
      chk_beat("t1", i, 0, 10, 100);
`ifdef RUNMIN_DRAIN_THRESH_EN
      chk("t1_match", out_match, (i <= 4) ? 1 : 0);
`endif
      tick;
    end
    chk("t1_end_valid", out_valid, 0);
    chk("t1_end_busy", busy, 0);

    // backpressure with ready pattern 1,0,0,1
    load(20, 200); set_cap(1'b1); tick; set_cap(1'b0);
    out_ready = 1'b0; tick;
    e = 0;
    for (int c = 0; c < 40 && e < NL; c++) begin
      out_ready = ((c % 4) == 0 || (c % 4) == 3);
      chk_beat("t2", e, 1, 20, 200);
      tick;
      if (out_ready) e++;
    end
    chk("t2_count", e, NL);
    chk("t2_end_valid", out_valid, 0);
    chk("t2_end_busy", busy, 0);

    // ping-pong: captures 3 cycles apart, gapless 16 beats
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk("t3_valid", out_valid, (c >= 2 && c < 18) ? 1 : 0);
      if (c >= 2 && c < 18) begin
        k = c - 2;
        chk_beat("t3", k % NL, 2 + k / NL, (k < NL) ? 30 : 40, (k < NL) ? 300 : 400);
      end
      if (c == 0) load(30, 300);
      if (c == 3) load(40, 400);
      set_cap(c == 0 || c == 3);
      tick;
    end
    set_cap(1'b0);

    // overflow: three captures with ready low
    rst = 1'b1; tick; rst = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      load(50 + 10 * c, 500 + 100 * c); set_cap(1'b1); tick;
      chk("t4_ovf", overflow, (c == 2) ? 1 : 0);
    end
    set_cap(1'b0);
    chk("t4_busy", busy, 1);
    chk_beat("t4_hold", 0, 0, 50, 500);
    out_ready = 1'b1;
    for (int i = 0; i < 2 * NL; i++) begin
      chk_beat("t4", i % NL, i / NL, (i < NL) ? 50 : 60, (i < NL) ? 500 : 600);
      tick;
    end
    chk("t4_end_valid", out_valid, 0);
    chk("t4_end_busy", busy, 0);
    chk("t4_sticky", overflow, 1);
    load(80, 800); set_cap(1'b1); tick; set_cap(1'b0); tick;
    for (int i = 0; i < NL; i++) begin
      chk_beat("t4_next", i, 3, 80, 800);
      tick;
    end

    // capture coinciding with final pop while both banks full
    rst = 1'b1; tick; rst = 1'b0;
    out_ready = 1'b0;
    load(100, 1000); set_cap(1'b1); tick;
    load(110, 1100); tick;
    set_cap(1'b0); tick;
    out_ready = 1'b1;
    for (int c = 0; c < 3 * NL; c++) begin
      chk_beat("t5", c % NL, c / NL, 100 + 10 * (c / NL), 1000 + 100 * (c / NL));
      chk("t5_ovf", overflow, 0);
      chk("t5_busy", busy, 1);
      if (c == NL - 1) begin load(120, 1200); set_cap(1'b1); end
      else set_cap(1'b0);
      tick;
    end
    set_cap(1'b0);
    chk("t5_end_valid", out_valid, 0);
    chk("t5_end_busy", busy, 0);

    // reset mid-stream on lane 4, with overflow set
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      load(130, 1300); set_cap(1'b1); tick;
    end
    set_cap(1'b0);
    chk("t6_ovf_set", overflow, 1);
    out_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (out_valid && out_lane == 3'd4) found = 1'b1;
      else tick;
    end
    chk("t6_found_lane4", found, 1);
    rst = 1'b1; tick; rst = 1'b0;
    chk("t6_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ovf", overflow, 0);
    tick; tick;
    chk("t6_quiet", out_valid, 0);
    load(200, 1500); set_cap(1'b1); tick; set_cap(1'b0); tick;
    chk_beat("t6_new", 0, 0, 200, 1500);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
